instruction_fetch_unit: RTL and testbench

- Front-end stage of the single-cycle RISC-V core, directly upstream of the main control decoder.
- Owns the program counter and fetches 32-bit instructions from instruction memory through a req/ack handshake.
- Presents a held instruction, with its Opcode field split out, to the decode/control stage.
- Computes the next PC from sequential increment or a taken branch (Branch && Zero), and faults on misaligned targets or memory timeout.

---
 rtl/instruction_fetch_unit.sv | 134 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: owns the PC, fetches over a req/ack handshake and holds the
// fetched word for decode until the core advances. Faults on misaligned targets or timeout.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] ImemAddr,
   output logic        ImemReq,
   input  logic        ImemAck,
   input  logic [31:0] ImemRdata,
   input  logic        Advance,
   input  logic        Branch,
   input  logic        Zero,
   input  logic [31:0] BranchOffset,
   output logic [31:0] PC,
   output logic [31:0] Instr,
   output logic [6:0]  Opcode,
   output logic        InstrValid,
   output logic        Fault,
   output logic [1:0]  FaultCause
   ,
   output logic [31:0] RetireCount
);

   typedef enum logic [1:0] {StIdle, StFetch, StHold, StFault} state_e;

   localparam logic [31:0] Nop          = 32'h0000_0013;
   localparam logic [7:0]  TimeoutLimit = 8'(TIMEOUT_CYCLES);
   localparam logic [1:0]  CauseNone    = 2'b00;
   localparam logic [1:0]  CauseAlign   = 2'b01;
   localparam logic [1:0]  CauseTimeout = 2'b10;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        valid_q, valid_d;
   logic        fault_q, fault_d;
   logic [1:0]  cause_q, cause_d;
   logic [31:0] retire_q, retire_d;
   logic [7:0]  tmo_q, tmo_d;
   logic [31:0] next_pc;

   // Candidate next PC; only meaningful on an Advance cycle in HOLD.
   always_comb begin
      next_pc = (Branch && Zero) ? (pc_q + BranchOffset) : (pc_q + 32'd4);
   end

   // Next-state logic for the fetch FSM and its datapath registers.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      valid_d  = valid_q;
      fault_d  = fault_q;
      cause_d  = cause_q;
      retire_d = retire_q;
      // Counter only runs while in FETCH, so it is zero on every entry.
      tmo_d    = '0;
      case (state_q)
         StIdle: begin
            state_d = StFetch;
         end
         StFetch: begin
            if (ImemAck) begin
               instr_d = ImemRdata;
               valid_d = 1'b1;
               state_d = StHold;
            end else if (tmo_q + 8'd1 == TimeoutLimit) begin
               fault_d = 1'b1;
               cause_d = CauseTimeout;
               state_d = StFault;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end
         StHold: begin
            if (Advance) begin
               valid_d = 1'b0;
               if (next_pc[1:0] == 2'b00) begin
                  pc_d     = next_pc;
                  retire_d = retire_q + 32'd1;
                  state_d  = StFetch;
               end else begin
                  fault_d = 1'b1;
                  cause_d = CauseAlign;
                  state_d = StFault;
               end
            end
         end
         default: begin
            valid_d = 1'b0;
         end
      endcase
   end

   // State and datapath registers, asynchronously reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         pc_q     <= RESET_PC;
         instr_q  <= Nop;
         valid_q  <= 1'b0;
         fault_q  <= 1'b0;
         cause_q  <= CauseNone;
         retire_q <= '0;
         tmo_q    <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         valid_q  <= valid_d;
         fault_q  <= fault_d;
         cause_q  <= cause_d;
         retire_q <= retire_d;
         tmo_q    <= tmo_d;
      end
   end

   // Outputs decode straight from state so reset drops ImemReq without a clock.
   always_comb begin
      ImemReq     = (state_q == StFetch);
      ImemAddr    = pc_q;
      PC          = pc_q;
      Instr       = instr_q;
      Opcode      = instr_q[6:0];
      InstrValid  = valid_q;
      Fault       = fault_q;
      FaultCause  = cause_q;
      RetireCount = retire_q;
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: expected fetch addresses are queued as the
// bench advances the core and compared when the DUT raises ImemReq.
module tb_instruction_fetch_unit;

   logic        clk;
   logic        rst;
   logic [31:0] ImemAddr;
   logic        ImemReq;
   logic        ImemAck;
   logic [31:0] ImemRdata;
   logic        Advance;
   logic        Branch;
   logic        Zero;
   logic [31:0] BranchOffset;
   logic [31:0] PC;
   logic [31:0] Instr;
   logic [6:0]  Opcode;
   logic        InstrValid;
   logic        Fault;
   logic [1:0]  FaultCause;
   logic [31:0] RetireCount;

   int unsigned n_chk;
   int unsigned n_err;
   logic [31:0] exp_q[$];
   logic [31:0] pc_m;
   logic [31:0] retire_m;

   instruction_fetch_unit #(
      .RESET_PC      (32'h0000_0000),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ImemAddr    (ImemAddr),
      .ImemReq     (ImemReq),
      .ImemAck     (ImemAck),
      .ImemRdata   (ImemRdata),
      .Advance     (Advance),
      .Branch      (Branch),
      .Zero        (Zero),
      .BranchOffset(BranchOffset),
      .PC          (PC),
      .Instr       (Instr),
      .Opcode      (Opcode),
      .InstrValid  (InstrValid),
      .Fault       (Fault),
      .FaultCause  (FaultCause),
      .RetireCount (RetireCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      Advance      = 1'b0;
      ImemAck      = 1'b0;
      Branch       = 1'b0;
      Zero         = 1'b0;
      BranchOffset = '0;
      ImemRdata    = 32'h0000_0033;
      repeat (2) tick();
      rst = 1'b0;
      pc_m     = 32'h0;
      retire_m = 32'h0;
      exp_q.delete();
   endtask

   // Wait (bounded) for a request, then score its address against the queue.
   task automatic wait_req(output bit ok);
      int n = 0;
      logic [31:0] exp;
      while (!ImemReq && n < 8) begin
         tick();
         n++;
      end
      ok = ImemReq;
      if (!ok) begin
         check_eq("req_seen", 32'(ImemReq), 32'h1);
      end else if (exp_q.size() == 0) begin
         check_eq("sb_nonempty", 32'(exp_q.size()), 32'h1);
      end else begin
         exp = exp_q.pop_front();
         check_eq("fetch_addr", ImemAddr, exp);
      end
   endtask

   // Complete a fetch with ack after `delay` stalled cycles, optionally holding Advance high
   // during the stall (it must be ignored outside HOLD).
   task automatic wait_fetch(input logic [31:0] word, input int delay, input logic adv_during);
      bit ok;
      wait_req(ok);
      if (!ok) return;
      ImemRdata = word;
      Advance   = adv_during;
      repeat (delay) tick();
      Advance = 1'b0;
      check_eq("stall_req", 32'(ImemReq), 32'h1);
      check_eq("stall_pc", PC, pc_m);
      check_eq("stall_retire", RetireCount, retire_m);
      ImemAck = 1'b1;
      tick();
      ImemAck = 1'b0;
      check_eq("hold_valid", 32'(InstrValid), 32'h1);
      check_eq("hold_instr", Instr, word);
      check_eq("hold_opcode", 32'(Opcode), 32'(word[6:0]));
      check_eq("hold_req", 32'(ImemReq), 32'h0);
   endtask

   // Advance from HOLD; model predicts either a new fetch or a misalignment fault.
   task automatic adv(input logic b, input logic z, input logic [31:0] off);
      logic [31:0] nxt;
      nxt = pc_m + ((b && z) ? off : 32'd4);
      Advance      = 1'b1;
      Branch       = b;
      Zero         = z;
      BranchOffset = off;
      tick();
      Advance      = 1'b0;
      Branch       = 1'b0;
      Zero         = 1'b0;
      BranchOffset = 32'h1234_5678;
      check_eq("adv_valid", 32'(InstrValid), 32'h0);
      if (nxt[1:0] == 2'b00) begin
         pc_m     = nxt;
         retire_m = retire_m + 32'd1;
         exp_q.push_back(nxt);
         check_eq("adv_pc", PC, pc_m);
         check_eq("adv_retire", RetireCount, retire_m);
      end else begin
         check_eq("align_fault", 32'(Fault), 32'h1);
         check_eq("align_cause", 32'(FaultCause), 32'h1);
         check_eq("align_pc", PC, pc_m);
         check_eq("align_retire", RetireCount, retire_m);
         check_eq("align_req", 32'(ImemReq), 32'h0);
      end
   endtask

   initial begin
      bit ok;
      n_chk = 0;
      n_err = 0;
      do_reset();

      // Reset state
      check_eq("rst_pc", PC, 32'h0);
      check_eq("rst_instr", Instr, 32'h0000_0013);
      check_eq("rst_valid", 32'(InstrValid), 32'h0);
      check_eq("rst_req", 32'(ImemReq), 32'h0);
      check_eq("rst_fault", 32'(Fault), 32'h0);
      check_eq("rst_cause", 32'(FaultCause), 32'h0);
      check_eq("rst_retire", RetireCount, 32'h0);

      // Sequential fetch 0,4,8 then 12
      exp_q.push_back(32'h0);
      wait_fetch(32'h0000_0033, 0, 1'b0);
      check_eq("opcode_r", 32'(Opcode), 32'h33);
      adv(1'b0, 1'b0, 32'h0);
      wait_fetch(32'h0000_0033, 0, 1'b0);
      adv(1'b0, 1'b0, 32'h0);
      wait_fetch(32'h0000_0033, 0, 1'b0);
      adv(1'b0, 1'b0, 32'h0);
      check_eq("retire3", RetireCount, 32'd3);
      wait_fetch(32'h0000_0033, 0, 1'b0);

      // Branch taken from 0x10 by -8, then not-taken from 0x10
      adv(1'b0, 1'b0, 32'h0);
      wait_fetch(32'h0000_0063, 0, 1'b0);
      adv(1'b1, 1'b1, 32'hFFFF_FFF8);
      check_eq("br_taken_pc", PC, 32'h0000_0008);
      wait_fetch(32'h0000_0033, 0, 1'b0);
      adv(1'b0, 1'b0, 32'h0);
      wait_fetch(32'h0000_0033, 0, 1'b0);
      adv(1'b0, 1'b0, 32'h0);
      wait_fetch(32'h0000_0063, 0, 1'b0);
      adv(1'b1, 1'b0, 32'hFFFF_FFF8);
      check_eq("br_nt_pc", PC, 32'h0000_0014);
      wait_fetch(32'h0000_0033, 0, 1'b0);

      // Advance during FETCH ignored; ack during HOLD ignored
      adv(1'b0, 1'b0, 32'h0);
      wait_fetch(32'h0000_0073, 3, 1'b1);
      ImemRdata = 32'hDEAD_BEEF;
      ImemAck   = 1'b1;
      tick();
      ImemAck = 1'b0;
      check_eq("hold_ack_instr", Instr, 32'h0000_0073);
      check_eq("hold_ack_valid", 32'(InstrValid), 32'h1);
      check_eq("hold_ack_pc", PC, 32'h0000_0018);

      // Ack on FETCH cycle 15 still succeeds
      adv(1'b0, 1'b0, 32'h0);
      wait_fetch(32'h0000_00B3, 14, 1'b0);
      check_eq("late_ack_fault", 32'(Fault), 32'h0);

      // No ack: timeout after 16 FETCH cycles
      adv(1'b0, 1'b0, 32'h0);
      wait_req(ok);
      repeat (15) tick();
      check_eq("tmo_pre_fault", 32'(Fault), 32'h0);
      check_eq("tmo_pre_req", 32'(ImemReq), 32'h1);
      tick();
      check_eq("tmo_fault", 32'(Fault), 32'h1);
      check_eq("tmo_cause", 32'(FaultCause), 32'h2);
      check_eq("tmo_req", 32'(ImemReq), 32'h0);
      check_eq("tmo_valid", 32'(InstrValid), 32'h0);
      check_eq("tmo_pc", PC, 32'h0000_0020);

      // Misaligned branch target faults and stays faulted
      do_reset();
      exp_q.push_back(32'h0);
      wait_fetch(32'h0000_0063, 0, 1'b0);
      adv(1'b1, 1'b1, 32'h0000_0006);
      Advance = 1'b1;
      ImemAck = 1'b1;
      repeat (3) tick();
      Advance = 1'b0;
      ImemAck = 1'b0;
      check_eq("flt_req", 32'(ImemReq), 32'h0);
      check_eq("flt_pc", PC, 32'h0);
      check_eq("flt_sticky", 32'(Fault), 32'h1);
      check_eq("flt_cause", 32'(FaultCause), 32'h1);
      check_eq("flt_retire", RetireCount, 32'h0);
      check_eq("flt_valid", 32'(InstrValid), 32'h0);

      // Reset mid-FETCH drops ImemReq asynchronously; late ack ignored
      do_reset();
      exp_q.push_back(32'h0);
      wait_req(ok);
      #2;
      rst = 1'b1;
      #1;
      check_eq("async_req", 32'(ImemReq), 32'h0);
      check_eq("async_instr", Instr, 32'h0000_0013);
      check_eq("async_valid", 32'(InstrValid), 32'h0);
      ImemRdata = 32'h0BAD_0BAD;
      ImemAck   = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      ImemAck = 1'b0;
      check_eq("late_ack_instr", Instr, 32'h0000_0013);
      check_eq("late_ack_valid", 32'(InstrValid), 32'h0);
      pc_m     = 32'h0;
      retire_m = 32'h0;
      exp_q.delete();
      exp_q.push_back(32'h0);
      wait_fetch(32'h0000_0033, 0, 1'b0);

      // Wrap from 0xFFFF_FFFC to 0
      adv(1'b1, 1'b1, 32'hFFFF_FFFC);
      wait_fetch(32'h0000_0033, 0, 1'b0);
      check_eq("wrap_hi_pc", PC, 32'hFFFF_FFFC);
      adv(1'b0, 1'b0, 32'h0);
      check_eq("wrap_pc", PC, 32'h0);
      wait_fetch(32'h0000_0033, 0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
